// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard and stall controller for the 5-stage MIPS pipeline. Each cycle it
// decides whether PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers
// advance, hold, flush or take a bubble. It handles:
// - load-use hazards
// - ID-stage branch operand hazards, including the two-bubble load-to-branch case
// - taken-branch/jump flushes
// - multi-cycle data-memory waits
// It also keeps saturating stall and flush counters.
//
// Ports:
//   clk_i, rst_n_i           clock, asynchronous active-low reset
//   IFID_Rs_i, IFID_Rt_i     source register fields of the instruction in ID
//   Branch_i, Taken_i        ID holds a beq / branch taken or jump decoded
//   IDEX_MemRd_i             EX holds a load
//   IDEX_RegWrite_i          EX writes a register
//   IDEX_WrReg_i             destination register of the instruction in EX
//   mem_req_i, mem_ack_i     data-memory access in MEM / access completes
//   PC_Wr_o .. MEMWB_Bubble_o  stage-register write enables, flush and bubbles
//   stall_cnt_o              cycles with PC_Wr_o=0 (saturating)
//   flush_cnt_o              cycles with IFID_Flush_o=1 (saturating)
module pipeline_hazard_ctrl (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [4:0]  IFID_Rs_i,
  input  logic [4:0]  IFID_Rt_i,
  input  logic        Branch_i,
  input  logic        Taken_i,
  input  logic        IDEX_MemRd_i,
  input  logic        IDEX_RegWrite_i,
  input  logic [4:0]  IDEX_WrReg_i,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  output logic        PC_Wr_o,
  output logic        IFID_Wr_o,
  output logic        IFID_Flush_o,
  output logic        IDEX_Wr_o,
  output logic        IDEX_Bubble_o,
  output logic        EXMEM_Wr_o,
  output logic        MEMWB_Bubble_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    BR_LD2   = 3'd1,
    MEM_WAIT = 3'd2
  } state_t;

  state_t state_q, state_d;
  state_t ret_q, ret_d;
  state_t eff_state;

  logic freeze;
  logic match;
  logic load_use;
  logic branch_alu;

  assign freeze     = mem_req_i && !mem_ack_i;
  assign match      = (IDEX_WrReg_i != 5'd0) &&
                      ((IDEX_WrReg_i == IFID_Rs_i) || (IDEX_WrReg_i == IFID_Rt_i));
  assign load_use   = IDEX_MemRd_i && match;
  assign branch_alu = Branch_i && IDEX_RegWrite_i && !IDEX_MemRd_i && match;

  // Once the memory ack arrives, MEM_WAIT behaves exactly like the state
  // it interrupted, so a pending BR_LD2 bubble survives a freeze.
  assign eff_state  = (state_q == MEM_WAIT) ? ret_q : state_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= RUN;
      ret_q   <= RUN;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    PC_Wr_o        = 1'b1;
    IFID_Wr_o      = 1'b1;
    IFID_Flush_o   = 1'b0;
    IDEX_Wr_o      = 1'b1;
    IDEX_Bubble_o  = 1'b0;
    EXMEM_Wr_o     = 1'b1;
    MEMWB_Bubble_o = 1'b0;
    state_d        = state_q;
    ret_d          = ret_q;

    if (freeze) begin
      PC_Wr_o        = 1'b0;
      IFID_Wr_o      = 1'b0;
      IDEX_Wr_o      = 1'b0;
      EXMEM_Wr_o     = 1'b0;
      MEMWB_Bubble_o = 1'b1;
      state_d        = MEM_WAIT;
      if (state_q != MEM_WAIT) begin
        ret_d = state_q;
      end
    end else begin
      case (eff_state)
        BR_LD2: begin
          PC_Wr_o       = 1'b0;
          IFID_Wr_o     = 1'b0;
          IDEX_Bubble_o = 1'b1;
          state_d       = RUN;
        end
        default: begin
          state_d = RUN;
          if (load_use) begin
            PC_Wr_o       = 1'b0;
            IFID_Wr_o     = 1'b0;
            IDEX_Bubble_o = 1'b1;
            if (Branch_i) begin
              state_d = BR_LD2;
            end
          end else if (branch_alu) begin
            PC_Wr_o       = 1'b0;
            IFID_Wr_o     = 1'b0;
            IDEX_Bubble_o = 1'b1;
          end else if (Taken_i) begin
            IFID_Flush_o = 1'b1;
          end
        end
      endcase
    end

    // Hold the whole pipeline with bubbles while reset is asserted.
    if (!rst_n_i) begin
      PC_Wr_o        = 1'b0;
      IFID_Wr_o      = 1'b0;
      IFID_Flush_o   = 1'b0;
      IDEX_Wr_o      = 1'b0;
      IDEX_Bubble_o  = 1'b1;
      EXMEM_Wr_o     = 1'b0;
      MEMWB_Bubble_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (!PC_Wr_o && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + 16'd1;
      end
      if (IFID_Flush_o && (flush_cnt_o != '1)) begin
        flush_cnt_o <= flush_cnt_o + 16'd1;
      end
    end
  end

endmodule
